// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Two-requester write arbiter in front of a single register file write port.
//   Requester 0 is the ALU writeback path and requester 1 is the load unit.
//   Ties are broken by a 1-bit round-robin pointer. An accepted write sits in
//   a one-entry holding stage and is presented to the register file on the
//   following cycle. The stage holds while the write port is stalled. Writes
//   to register 0 are accepted but never strobed, which keeps x0 hardwired to 0.
//
// Ports
//   clk           clock; all state updates on its rising edge
//   rst           asynchronous active-high reset
//   req0_valid    requester 0 (ALU) presents a write
//   req0_addr     requester 0 destination register
//   req0_data     requester 0 write data
//   req0_ready    requester 0 granted this cycle
//   req1_*        same as req0_*, for requester 1 (load unit)
//   wr_stall      register file write port unavailable this cycle
//   wr_en         register file write strobe
//   wr_addr       register file write address
//   wr_data       register file write data
//   pending_mask  one bit per register with an accepted, uncommitted write
module rf_write_arbiter #(
    parameter int WIDTH     = 32,
    parameter int REG_COUNT = 32,
    parameter int REG_BITS  = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [REG_BITS-1:0]  req0_addr,
    input  logic [WIDTH-1:0]     req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [REG_BITS-1:0]  req1_addr,
    input  logic [WIDTH-1:0]     req1_data,
    output logic                 req1_ready,
    input  logic                 wr_stall,
    output logic                 wr_en,
    output logic [REG_BITS-1:0]  wr_addr,
    output logic [WIDTH-1:0]     wr_data,
    output logic [REG_COUNT-1:0] pending_mask
);

    logic                valid_q;
    logic [REG_BITS-1:0] addr_q;
    logic [WIDTH-1:0]    data_q;
    logic                src_q;
    logic                ptr_q;

    logic can_accept;
    logic grant0;
    logic grant1;

    // The stage can take a new write when it is empty or draining this cycle.
    assign can_accept = ~valid_q | ~wr_stall;

    // Readies are combinational from valid, so they are masked by rst to keep
    // both requesters idle while the block is held in reset.
    assign grant0 = ~rst & can_accept & req0_valid & (~req1_valid | ~ptr_q);
    assign grant1 = ~rst & can_accept & req1_valid & (~req0_valid |  ptr_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            src_q   <= 1'b0;
            ptr_q   <= 1'b0;
        end else if (grant0) begin
            valid_q <= 1'b1;
            addr_q  <= req0_addr;
            data_q  <= req0_data;
            src_q   <= 1'b0;
            ptr_q   <= 1'b1;
        end else if (grant1) begin
            valid_q <= 1'b1;
            addr_q  <= req1_addr;
            data_q  <= req1_data;
            src_q   <= 1'b1;
            ptr_q   <= 1'b0;
        end else if (valid_q && !wr_stall) begin
            valid_q <= 1'b0;
        end
    end

    assign wr_en   = valid_q & ~wr_stall & (addr_q != '0);
    assign wr_addr = addr_q;
    assign wr_data = data_q;

    // Bit 0 is never set because the loop starts at register 1.
    always_comb begin
        pending_mask = '0;
        if (valid_q && (addr_q != '0)) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (addr_q == REG_BITS'(i)) begin
                    pending_mask[i] = 1'b1;
                end
            end
        end
    end

    // src_q records which requester produced the held write, for debug
    // visibility; no output depends on it.
    logic unused_src;
    assign unused_src = src_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    localparam int WIDTH     = 32;
    localparam int REG_COUNT = 32;
    localparam int REG_BITS  = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req0_valid;
    logic [REG_BITS-1:0]  req0_addr;
    logic [WIDTH-1:0]     req0_data;
    logic                 req0_ready;
    logic                 req1_valid;
    logic [REG_BITS-1:0]  req1_addr;
    logic [WIDTH-1:0]     req1_data;
    logic                 req1_ready;
    logic                 wr_stall;
    logic                 wr_en;
    logic [REG_BITS-1:0]  wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic [REG_COUNT-1:0] pending_mask;

    int unsigned passed = 0;
    int unsigned total  = 0;

    rf_write_arbiter #(
        .WIDTH(WIDTH), .REG_COUNT(REG_COUNT), .REG_BITS(REG_BITS)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs are then changed mid-cycle.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between clock edges.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic idle_reqs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h1111_1111;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h2222_2222;
        wr_stall = 1'b0;
        #2;
        check("rst_ready0", 64'(req0_ready), 64'd0);
        check("rst_ready1", 64'(req1_ready), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_mask", 64'(pending_mask), 64'd0);
        next();
        rst = 1'b0;
        idle_reqs();

        // Single write
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
        #1;
        check("single_ready0", 64'(req0_ready), 64'd1);
        check("single_ready1", 64'(req1_ready), 64'd0);
        check("single_c0_wr_en", 64'(wr_en), 64'd0);
        next();
        idle_reqs();
        #1;
        check("single_wr_en", 64'(wr_en), 64'd1);
        check("single_wr_addr", 64'(wr_addr), 64'd5);
        check("single_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
        check("single_mask", 64'(pending_mask), 64'h20);
        next();
        check("single_drain_wr_en", 64'(wr_en), 64'd0);
        check("single_drain_mask", 64'(pending_mask), 64'd0);

        // Tie: alternates req0, req1, req0, req1 starting from reset
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_0AAA;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_0BBB;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("tie_ready0", 64'(req0_ready), 64'(i % 2 == 0));
            check("tie_ready1", 64'(req1_ready), 64'(i % 2 == 1));
            check("tie_wr_en", 64'(wr_en), 64'(i > 0));
            if (i > 0) begin
                check("tie_wr_addr", 64'(wr_addr), (i % 2 == 1) ? 64'd1 : 64'd2);
                check("tie_wr_data", 64'(wr_data), (i % 2 == 1) ? 64'hAAA : 64'hBBB);
            end
            next();
        end
        idle_reqs();
        #1;
        check("tie_last_wr_en", 64'(wr_en), 64'd1);
        check("tie_last_wr_addr", 64'(wr_addr), 64'd2);
        next();
        check("tie_drain_wr_en", 64'(wr_en), 64'd0);

        // Stall: addr 7 held for 3 stalled cycles; pointer is 0 here
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0077;
        #1;
        check("stall_accept", 64'(req0_ready), 64'd1);
        next();
        wr_stall = 1'b1;
        req0_addr = 5'd8; req0_data = 32'h0000_0088;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h0000_0044;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_wr_en", 64'(wr_en), 64'd0);
            check("stall_mask", 64'(pending_mask), 64'h80);
            check("stall_ready0", 64'(req0_ready), 64'd0);
            check("stall_ready1", 64'(req1_ready), 64'd0);
            next();
        end
        wr_stall = 1'b0;
        #1;
        check("stall_commit_wr_en", 64'(wr_en), 64'd1);
        check("stall_commit_addr", 64'(wr_addr), 64'd7);
        check("stall_commit_data", 64'(wr_data), 64'h77);
        // Pointer is 1 after the req0 grant, so the tie goes to req1.
        check("stall_regrant0", 64'(req0_ready), 64'd0);
        check("stall_regrant1", 64'(req1_ready), 64'd1);
        next();
        idle_reqs();
        #1;
        check("stall_next_addr", 64'(wr_addr), 64'd4);
        check("stall_next_wr_en", 64'(wr_en), 64'd1);
        next();

        // x0 write: accepted, never strobed; req0 inputs garbage but invalid
        req0_addr = 5'd31; req0_data = 32'hFFFF_FFFF;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
        #1;
        check("x0_ready1", 64'(req1_ready), 64'd1);
        check("x0_ready0", 64'(req0_ready), 64'd0);
        next();
        idle_reqs();
        #1;
        check("x0_wr_en", 64'(wr_en), 64'd0);
        check("x0_mask", 64'(pending_mask), 64'd0);
        next();

        // Reset while addr 9 is held
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0000_0099;
        #1;
        check("rmid_accept", 64'(req0_ready), 64'd1);
        next();
        idle_reqs();
        wr_stall = 1'b1;
        #1;
        check("rmid_mask_held", 64'(pending_mask), 64'h200);
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h0000_0999;
        rst = 1'b1;
        #1;
        check("rmid_mask", 64'(pending_mask), 64'd0);
        check("rmid_wr_addr", 64'(wr_addr), 64'd0);
        check("rmid_wr_data", 64'(wr_data), 64'd0);
        check("rmid_ready1", 64'(req1_ready), 64'd0);
        #1;
        rst = 1'b0;
        idle_reqs();
        wr_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rmid_no_write", 64'(wr_en), 64'd0);
            next();
        end

        // Same-address collision after reset: 0xA then 0xB
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_000A;
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h0000_000B;
        #1;
        check("coll_first_ready0", 64'(req0_ready), 64'd1);
        check("coll_first_ready1", 64'(req1_ready), 64'd0);
        next();
        check("coll_second_ready1", 64'(req1_ready), 64'd1);
        check("coll_a_wr_en", 64'(wr_en), 64'd1);
        check("coll_a_addr", 64'(wr_addr), 64'd3);
        check("coll_a_data", 64'(wr_data), 64'hA);
        check("coll_a_mask", 64'(pending_mask), 64'h8);
        next();
        idle_reqs();
        #1;
        check("coll_b_wr_en", 64'(wr_en), 64'd1);
        check("coll_b_data", 64'(wr_data), 64'hB);
        next();
        check("coll_drain_wr_en", 64'(wr_en), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
